// File: rtl/sayeh_pkg.sv
// Shared types and constants for the Sayeh windowed register file
// spill/fill engine.
package sayeh_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        WRB  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic OP_SPILL = 1'b0;
    localparam logic OP_FILL  = 1'b1;
    localparam int   RF_DEPTH = 64;

endpackage

// File: rtl/rf_window_mover.sv
// Sequential spill/fill engine moving up to 7 registers between the
// windowed register file and data memory, one word per handshake.
module rf_window_mover
    import sayeh_pkg::*;
#(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int RFAW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op,
    input  logic [RFAW-1:0] win_base,
    input  logic [AW-1:0]   mem_base,
    input  logic [2:0]      cnt,
    output logic [RFAW-1:0] rf_addr,
    input  logic [DW-1:0]   rf_rdata,
    output logic [DW-1:0]   rf_wdata,
    output logic            rf_lwrite,
    output logic            rf_hwrite,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            busy,
    output logic            done
);

    state_t          r_state;
    state_t          w_next;
    logic            r_op;
    logic [RFAW-1:0] r_win;
    logic [AW-1:0]   r_mem;
    logic [2:0]      r_cnt;
    logic [2:0]      r_idx;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_rf_wdata;
    logic            w_last;
    logic [RFAW-1:0] w_rf_addr;
    logic [AW-1:0]   w_mem_addr;

    // Addresses wrap naturally at their own widths.
    assign w_rf_addr  = r_win + RFAW'(r_idx);
    assign w_mem_addr = r_mem + AW'(r_idx);
    assign w_last     = ((r_idx + 3'd1) == r_cnt);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = (cnt == 3'd0) ? FIN : LOAD;
            LOAD: w_next = REQ;
            REQ: begin
                if (mem_ack) begin
                    if (r_op == OP_FILL) w_next = WRB;
                    else                 w_next = w_last ? FIN : LOAD;
                end
            end
            WRB:     w_next = w_last ? FIN : LOAD;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rf_lwrite = 1'b0;
        rf_hwrite = 1'b0;
        rf_addr   = '0;
        mem_addr  = '0;
        unique case (r_state)
            LOAD: begin
                busy     = 1'b1;
                rf_addr  = w_rf_addr;
                mem_addr = w_mem_addr;
            end
            REQ: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = ~r_op;
                rf_addr  = w_rf_addr;
                mem_addr = w_mem_addr;
            end
            WRB: begin
                busy      = 1'b1;
                rf_lwrite = 1'b1;
                rf_hwrite = 1'b1;
                rf_addr   = w_rf_addr;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign mem_wdata = r_mem_wdata;
    assign rf_wdata  = r_rf_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_SPILL;
            r_win       <= '0;
            r_mem       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_mem_wdata <= '0;
            r_rf_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_op  <= op;
                r_win <= win_base;
                r_mem <= mem_base;
                r_cnt <= cnt;
                r_idx <= '0;
            end
            if (r_state == LOAD && r_op == OP_SPILL) r_mem_wdata <= rf_rdata;
            if (r_state == REQ && mem_ack) begin
                if (r_op == OP_FILL) r_rf_wdata <= mem_rdata;
                else                 r_idx      <= r_idx + 3'd1;
            end
            if (r_state == WRB) r_idx <= r_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_rf_window_mover.sv
// Randomized bench for rf_window_mover with register file and memory
// models and a transaction-level reference.
module tb_rf_window_mover;
    import sayeh_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [5:0]  win_base;
    logic [15:0] mem_base;
    logic [2:0]  cnt;
    logic [5:0]  rf_addr;
    logic [15:0] rf_rdata;
    logic [15:0] rf_wdata;
    logic        rf_lwrite;
    logic        rf_hwrite;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;

    rf_window_mover #(.AW(16), .DW(16), .RFAW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .win_base(win_base), .mem_base(mem_base), .cnt(cnt),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata),
        .rf_lwrite(rf_lwrite), .rf_hwrite(rf_hwrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [5:0]  ra;
    } acc_t;

    logic [15:0] rf  [RF_DEPTH];
    logic [15:0] mem [65536];
    logic [15:0] rf_pre [RF_DEPTH];
    acc_t        acc [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_strobe = 0;
    int          n_done = 0;
    int          delay_sum = 0;
    int          fix_delay = 0;
    int          max_delay = 0;
    bit          stray = 0;

    assign rf_rdata = rf[rf_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder and register file write port.
    initial begin
        int wcnt;
        int cur_d;
        wcnt = -1;
        cur_d = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (rf_lwrite && rf_hwrite) begin
                rf[rf_addr] = rf_wdata;
                n_strobe++;
            end
            if (rst) begin
                wcnt = -1;
            end else if (mem_req) begin
                if (wcnt < 0) begin
                    cur_d = (fix_delay >= 0) ? fix_delay : $urandom_range(0, max_delay);
                    wcnt = cur_d;
                end
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    acc.push_back('{mem_addr, mem_we, mem_wdata, rf_addr});
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                    delay_sum += cur_d;
                    wcnt = -1;
                end else begin
                    wcnt--;
                end
            end else begin
                wcnt = -1;
                if (stray) mem_ack = 1'b1;
            end
        end
    end

    // Cycle-by-cycle protocol checks.
    initial begin
        logic        p_req;
        logic        p_done;
        logic [32:0] p_bus;
        p_req = 1'b0;
        p_done = 1'b0;
        p_bus = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 1'b0;
                p_done = 1'b0;
            end else begin
                if (!busy && !done)
                    check("idle_quiet", {mem_req, rf_lwrite, rf_hwrite}, 0);
                if (rf_lwrite || rf_hwrite)
                    check("strobe_pair", rf_lwrite, rf_hwrite);
                if (mem_req && p_req)
                    check("req_stable", {mem_addr, mem_wdata, mem_we}, p_bus);
                if (done) begin
                    check("done_pulse", {busy, p_done}, 0);
                    n_done++;
                end
                p_req = mem_req;
                p_done = done;
                p_bus = {mem_addr, mem_wdata, mem_we};
            end
        end
    end

    task automatic run_op(input logic o, input logic [5:0] wb,
                          input logic [15:0] mb, input logic [2:0] c,
                          input int fd, input int md, input bit st,
                          input bit retrig, output int lat);
        int s;
        int waited;
        int busy_cnt;
        int nbad;
        logic [15:0] exp_rf [RF_DEPTH];
        logic [15:0] ea;
        logic [5:0]  er;
        rf_pre = rf;
        acc.delete();
        delay_sum = 0;
        n_strobe = 0;
        fix_delay = fd;
        max_delay = md;
        stray = st;
        lat = 0;
        @(negedge clk);
        start = 1'b1; op = o; win_base = wb; mem_base = mb; cnt = c;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        op = 1'($urandom); win_base = 6'($urandom);
        mem_base = 16'($urandom); cnt = 3'($urandom);
        waited = 0;
        busy_cnt = 0;
        while (!done && waited < 300) begin
            if (busy) busy_cnt++;
            start = (retrig && waited == 1);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        stray = 0;
        if (waited >= 300) begin
            check("done_timeout", 1, 0);
            return;
        end
        lat = cyc - s;
        check("latency", lat, 1 + int'(c) * (o ? 3 : 2) + delay_sum);
        check("busy_cycles", busy_cnt, lat - 1);
        check("xfer_count", acc.size(), c);
        check("strobe_count", n_strobe, o ? int'(c) : 0);
        exp_rf = rf_pre;
        for (int k = 0; k < acc.size() && k < int'(c); k++) begin
            ea = mb + 16'(k);
            er = wb + 6'(k);
            check("acc_addr", acc[k].addr, ea);
            check("acc_we", acc[k].we, !o);
            check("acc_rfaddr", acc[k].ra, er);
            if (o == OP_SPILL) begin
                check("spill_data", acc[k].wdata, rf_pre[er]);
                check("spill_mem", mem[ea], rf_pre[er]);
            end else begin
                exp_rf[er] = mem[ea];
            end
        end
        nbad = 0;
        for (int r = 0; r < RF_DEPTH; r++)
            if (rf[r] !== exp_rf[r]) nbad++;
        check("rf_image", nbad, 0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int waited;
        int nd;
        logic [15:0] exp_ra [4];
        logic [15:0] exp_ma [4];
        for (int r = 0; r < RF_DEPTH; r++) rf[r] = 16'($urandom);
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        rst = 1'b1; start = 1'b0; op = 1'b0;
        win_base = '0; mem_base = '0; cnt = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {busy, done, mem_req, mem_we, rf_lwrite, rf_hwrite}, 0);
        check("rst_bus", {rf_addr, mem_addr, mem_wdata, rf_wdata}, 0);
        rst = 1'b0;

        rf[8] = 16'h1111; rf[9] = 16'h2222; rf[10] = 16'h3333; rf[11] = 16'h4444;
        run_op(OP_SPILL, 6'd8, 16'h0100, 3'd4, 0, 0, 0, 0, lat);
        check("spill_lat", lat, 9);
        check("spill_mem0", mem[16'h0100], 16'h1111);
        check("spill_mem3", mem[16'h0103], 16'h4444);

        mem[16'h0200] = 16'hA5A5; mem[16'h0201] = 16'h5A5A; mem[16'h0202] = 16'hFFFF;
        run_op(OP_FILL, 6'd20, 16'h0200, 3'd3, 0, 0, 0, 0, lat);
        check("fill_lat", lat, 10);
        check("fill_rf", {rf[20], rf[21], rf[22]}, 48'hA5A5_5A5A_FFFF);
        check("fill_strobes", n_strobe, 3);

        exp_ra = '{16'd62, 16'd63, 16'd0, 16'd1};
        exp_ma = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_op(OP_SPILL, 6'd62, 16'hFFFE, 3'd4, 3, 0, 0, 0, lat);
        check("wrap_lat", lat, 21);
        for (int k = 0; k < 4 && k < acc.size(); k++) begin
            check("wrap_rfaddr", acc[k].ra, exp_ra[k]);
            check("wrap_memaddr", acc[k].addr, exp_ma[k]);
        end

        run_op(OP_SPILL, 6'd3, 16'h0050, 3'd0, 0, 0, 0, 0, lat);
        check("cnt0_lat", lat, 1);

        run_op(OP_SPILL, 6'd5, 16'h0300, 3'd3, 0, 0, 0, 1, lat);
        check("retrig_lat", lat, 7);

        run_op(OP_FILL, 6'd40, 16'h0400, 3'd2, 1, 0, 1, 0, lat);
        check("stray_lat", lat, 9);

        rf_pre = rf;
        acc.delete();
        fix_delay = 5;
        nd = n_done;
        @(negedge clk);
        start = 1'b1; op = OP_FILL; win_base = 6'd30; mem_base = 16'h0500; cnt = 3'd4;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(mem_req && rf_addr == 6'd31) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("rstmid_timeout", 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ctrl", {busy, done, mem_req, mem_we, rf_lwrite, rf_hwrite}, 0);
        check("rstmid_bus", {rf_addr, mem_addr, mem_wdata, rf_wdata}, 0);
        repeat (3) @(negedge clk);
        check("rstmid_nodone", n_done, nd);
        check("rstmid_rf0", rf[30], mem[16'h0500]);
        check("rstmid_rest", {rf[31], rf[32], rf[33]}, {rf_pre[31], rf_pre[32], rf_pre[33]});

        for (int t = 0; t < 30; t++)
            run_op(1'($urandom), 6'($urandom), 16'($urandom), 3'($urandom),
                   -1, $urandom_range(0, 3), 1'($urandom), 1'($urandom), lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_window_mover.md
Name: rf_window_mover

Overview:
- Sequential spill/fill engine for the Sayeh windowed register file.
- Spill: reads up to 7 consecutive registers starting at a window base and writes them to data memory.
- Fill: reads consecutive memory words and writes them into the register file through its byte-lane write strobes (both lanes asserted).
- Sits between the controller (context save/restore on window change) and the memory interface, driving the register file's external address/write port.

Parameters:
- AW, 16, memory address width.
- DW, 16, data width; must equal the register file word width.
- RFAW, 6, register file address width; 64 entries.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = spill (RF to memory), 1 = fill (memory to RF).
- win_base  in  6  first register file address.
- mem_base  in  AW  first memory word address.
- cnt  in  3  number of registers to move, 0..7.
- rf_addr  out  6  register file address, driven during transfer.
- rf_rdata  in  DW  register file combinational read data at rf_addr.
- rf_wdata  out  DW  register file write data.
- rf_lwrite  out  1  low-byte write strobe.
- rf_hwrite  out  1  high-byte write strobe.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle acknowledge; ignored when mem_req is low.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; busy, done, mem_req, mem_we, rf_lwrite, rf_hwrite = 0; rf_addr, mem_addr, mem_wdata, rf_wdata = 0; index counter = 0.
- States: IDLE, LOAD, REQ, WRB, FIN.
- IDLE: on start, latch op, win_base, mem_base and cnt; clear index i.
  - cnt == 0: go to FIN, with no memory or register file traffic.
  - otherwise: go to LOAD.
- LOAD (1 cycle): rf_addr = win_base + i, 6-bit wrap modulo 64; mem_addr = mem_base + i, AW-bit wrap.
  - Spill: capture rf_rdata into mem_wdata at the end of this cycle.
  - Go to REQ.
- REQ: mem_req = 1, mem_we = ~op; mem_addr and mem_wdata are stable while mem_req is high. Wait for mem_ack.
  - Spill, on ack: i++. If i == cnt, go to FIN; else go to LOAD.
  - Fill, on ack: capture mem_rdata into rf_wdata and go to WRB.
  - mem_req deasserts in the cycle after ack.
- WRB (fill only, 1 cycle): rf_lwrite = rf_hwrite = 1 with rf_addr = win_base + i; the register file commits at the next posedge.
  - Then i++ and go to LOAD, or to FIN when i reaches cnt.
- FIN: done = 1 for exactly one cycle, busy = 0 in the same cycle, then IDLE.
- busy = 1 in LOAD, REQ and WRB.
- Minimum cost per register, with ack in the first REQ cycle: spill 2 cycles, fill 3 cycles.
  - Total latency from the start edge to done = 1 + per-register cost × cnt.
- start while not IDLE is ignored; no queueing. Input changes after start is accepted have no effect.
- Early ack: mem_ack outside REQ is ignored.
- Reset mid-operation:
  - Returns to IDLE within the same edge; no done pulse.
  - Registers and memory words already written stay written; no rollback.
  - A strobe asserted in the reset cycle still commits at that edge. Only the strobe is driven by this block; the register file itself has no reset.
- Window wrap: win_base = 62 with cnt = 4 touches addresses 62, 63, 0, 1.

Decomposition:
- Shared package sayeh_pkg holds:
  - the state encoding enum: IDLE = 0, LOAD = 1, REQ = 2, WRB = 3, FIN = 4;
  - the op constants OP_SPILL = 0, OP_FILL = 1;
  - RF_DEPTH = 64.
- No sub-module. The address/index counter and the FSM stay in one module.

Test Plan:
- Spill: RF[8..11] preloaded with 0x1111, 0x2222, 0x3333, 0x4444; start, op = 0, win_base = 8, mem_base = 0x0100, cnt = 4, ack on the first REQ cycle -> mem writes to 0x0100..0x0103 with those values in order; done at cycle 9 after start; busy high cycles 1..8.
- Fill: memory 0x0200..0x0202 = 0xA5A5, 0x5A5A, 0xFFFF; op = 1, win_base = 20, cnt = 3 -> RF[20..22] hold those values; rf_lwrite/rf_hwrite pulse exactly 3 times, each one cycle; done at cycle 10.
- Wrap and backpressure: spill with win_base = 62, cnt = 4, mem_base = 0xFFFE, ack delayed 3 cycles per request -> rf_addr sequence 62, 63, 0, 1; mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; mem_addr and mem_wdata stable throughout each wait.
- Boundary: cnt = 0 -> no mem_req, no RF strobe, done at cycle 1. start asserted while busy -> ignored; the transfer count is unchanged.
- Reset mid-fill: assert rst in the second REQ of a cnt = 4 fill -> next cycle IDLE, all outputs 0, no done pulse; RF[base] written, RF[base+1..] unchanged.
- Stray ack: pulse mem_ack in IDLE and in LOAD -> no state change and no extra transfers.
